// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce scheduler: FSM encoding and a clog2 helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so every derived vector has a legal width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_timer.sv
// Shared stability timer: counts while enabled and parks at COUNT_MAX-1.
module debounce_timer
  import debounce_pkg::*;
#(
  parameter int COUNT_MAX = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CNT_W = clog2(COUNT_MAX + 1);

  logic [CNT_W-1:0] r_count;
  logic             w_done;

  assign w_done = (r_count == CNT_W'(COUNT_MAX - 1));
  assign done   = w_done;

  // Counter: cleared on each grant, saturates at the terminal value so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en && !w_done) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Time-shares one debounce timer across N buttons with a round-robin grant.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int COUNT_MAX = 500000,
  localparam int IDX_W     = clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     btn_in,
  output logic [N-1:0]     btn_level,
  output logic [N-1:0]     btn_pulse,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  state_t           r_state, w_state_next;
  logic [N-1:0]     r_sync1, r_sync2;
  logic [N-1:0]     r_level, w_level_next;
  logic [N-1:0]     r_pulse, w_pulse_next;
  logic             r_busy;
  logic [IDX_W-1:0] r_grant, w_grant_next;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_next;
  logic [N-1:0]     w_mismatch;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_cand;
  logic             w_tmr_clear, w_tmr_en, w_tmr_done;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sync
      // Two-flop synchroniser for the raw, asynchronous button level.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync1[gi] <= 1'b0;
          r_sync2[gi] <= 1'b0;
        end else begin
          r_sync1[gi] <= btn_in[gi];
          r_sync2[gi] <= r_sync1[gi];
        end
      end
      assign w_mismatch[gi] = r_sync2[gi] ^ r_level[gi];
    end
  endgenerate

  // Round-robin search: first mismatching input starting just after the last owner.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % N);
      if (!w_found && w_mismatch[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  debounce_timer #(
    .COUNT_MAX(COUNT_MAX)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(w_tmr_clear),
    .en   (w_tmr_en),
    .done (w_tmr_done)
  );

  // Next-state logic: grant, count/abort, then commit the level and maybe pulse.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_rr_next    = r_rr_ptr;
    w_level_next = r_level;
    w_pulse_next = '0;
    w_tmr_clear  = 1'b0;
    w_tmr_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_next = w_sel;
          w_tmr_clear  = 1'b1;
          w_state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        w_tmr_en = 1'b1;
        // A bounce back to the committed level wins over timer expiry.
        if (!w_mismatch[r_grant]) begin
          w_rr_next    = r_grant;
          w_state_next = ST_IDLE;
        end else if (w_tmr_done) begin
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_mismatch[r_grant]) begin
          w_level_next[r_grant] = ~r_level[r_grant];
          if (!r_level[r_grant]) begin
            w_pulse_next[r_grant] = 1'b1;
          end
        end
        w_rr_next    = r_grant;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; busy is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_level  <= '0;
      r_pulse  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_rr_ptr <= w_rr_next;
      r_level  <= w_level_next;
      r_pulse  <= w_pulse_next;
      r_busy   <= (w_state_next != ST_IDLE);
    end
  end

  assign btn_level = r_level;
  assign btn_pulse = r_pulse;
  assign busy      = r_busy;
  assign grant_idx = r_grant;

endmodule
